// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - fetch-stage bus bundle: imem read port, decode stream, branch redirect
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, instr, instr_pc, instr_valid,
    input  imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_pc, instr_valid,
    output imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage with one-entry buffer and branch squash
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
);
  typedef enum logic [1:0] {IDLE, FETCH, VALID, FLUSH} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] flush_addr_q, flush_addr_d;
  logic [31:0] target;

  assign target = {bus.redirect_pc[31:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      instr_q      <= 32'h0;
      ipc_q        <= 32'h0;
      flush_addr_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      ipc_q        <= ipc_d;
      flush_addr_q <= flush_addr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    ipc_d        = ipc_q;
    flush_addr_d = flush_addr_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (bus.redirect) begin
          pc_d = target;
          // Un-acked request is still owed by memory; park its address and drain it.
          if (!bus.imem_ack) begin
            state_d      = FLUSH;
            flush_addr_d = pc_q;
          end
        end else if (bus.imem_ack) begin
          instr_d = bus.imem_rdata;
          ipc_d   = pc_q;
          pc_d    = pc_q + 32'd4;
          state_d = VALID;
        end
      end
      VALID: begin
        if (bus.redirect) begin
          pc_d    = target;
          state_d = FETCH;
        end else if (bus.instr_ready) begin
          state_d = FETCH;
        end
      end
      FLUSH: begin
        if (bus.redirect) pc_d = target;
        if (bus.imem_ack) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.imem_req    = (state_q == FETCH) || (state_q == FLUSH);
  assign bus.imem_addr   = (state_q == FETCH) ? pc_q :
                           (state_q == FLUSH) ? flush_addr_q : 32'h0;
  assign bus.instr_valid = (state_q == VALID);
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = ipc_q;
endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed plus random bench for instr_fetch against a transaction-level model
module tb_instr_fetch;
  localparam logic [31:0] RPC = 32'h0000_0100;

  logic clk = 1'b0;
  logic rst;
  instr_fetch_if ifc ();

  instr_fetch #(.RESET_PC(RPC)) dut (.clk(clk), .rst(rst), .bus(ifc));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model: outstanding request (with squash flag), a queue of buffered instructions, next pc.
  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
  } ent_t;
  ent_t        buf_q[$];
  bit          m_started;
  bit          m_out;
  bit          m_stale;
  logic [31:0] m_out_addr;
  logic [31:0] m_pc;
  logic [31:0] last_data;
  logic [31:0] last_pc;

  logic        o_req, o_valid;
  logic [31:0] o_addr, o_instr, o_ipc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic ack, input logic [31:0] rd,
                            input logic rdy, input logic rdr, input logic [31:0] rpc);
    bit had_buf;
    if (r) begin
      buf_q.delete();
      m_started = 0; m_out = 0; m_stale = 0; m_out_addr = 0;
      m_pc = RPC; last_data = 0; last_pc = 0;
      return;
    end
    if (!m_started) begin
      m_started = 1;
      m_out = 1; m_stale = 0; m_out_addr = m_pc;
      return;
    end
    had_buf = (buf_q.size() != 0);
    if (m_out && ack) begin
      if (!m_stale && !rdr) begin
        buf_q.push_back('{data: rd, pc: m_out_addr});
        last_data = rd;
        last_pc   = m_out_addr;
        m_pc      = m_out_addr + 32'd4;
      end
      m_out = 0;
    end
    if (rdr) begin
      m_pc = rpc & ~32'h3;
      if (m_out) m_stale = 1;
    end
    if (had_buf && (rdr || rdy)) void'(buf_q.pop_front());
    if (!m_out && buf_q.size() == 0) begin
      m_out = 1; m_stale = 0; m_out_addr = m_pc;
    end
  endtask

  // One clock: observe outputs mid-cycle, check against the model, drive inputs, advance both.
  task automatic cycle(input logic r, input logic ack, input logic [31:0] rd,
                       input logic rdy, input logic rdr, input logic [31:0] rpc);
    @(negedge clk);
    o_req = ifc.imem_req; o_addr = ifc.imem_addr; o_valid = ifc.instr_valid;
    o_instr = ifc.instr; o_ipc = ifc.instr_pc;
    chk("imem_req", {31'b0, o_req}, {31'b0, m_out});
    chk("imem_addr", o_addr, m_out ? m_out_addr : 32'h0);
    chk("instr_valid", {31'b0, o_valid}, {31'b0, buf_q.size() != 0});
    chk("instr", o_instr, last_data);
    chk("instr_pc", o_ipc, last_pc);
    rst = r;
    ifc.imem_ack = ack; ifc.imem_rdata = rd; ifc.instr_ready = rdy;
    ifc.redirect = rdr; ifc.redirect_pc = rpc;
    @(posedge clk);
    model_step(r, ack, rd, rdy, rdr, rpc);
  endtask

  initial begin
    logic [31:0] d;
    rst = 1'b1;
    ifc.imem_ack = 0; ifc.imem_rdata = 0; ifc.instr_ready = 0;
    ifc.redirect = 0; ifc.redirect_pc = 0;
    @(posedge clk);
    model_step(1, 0, 0, 0, 0, 0);

    // Reset then zero-wait streaming from 0x100
    cycle(1, 1, 32'hDEAD_0000, 1, 0, 0);
    chk("rst_req", {31'b0, o_req}, 32'h0);
    chk("rst_valid", {31'b0, o_valid}, 32'h0);
    cycle(0, 1, 32'hDEAD_0001, 1, 0, 0);
    chk("idle_req", {31'b0, o_req}, 32'h0);
    cycle(0, 1, 32'h1111_0000, 1, 0, 0);
    chk("zw_addr0", o_addr, 32'h100);
    cycle(0, 1, 32'h0, 1, 0, 0);
    chk("zw_ipc0", o_ipc, 32'h100);
    chk("zw_instr0", o_instr, 32'h1111_0000);
    cycle(0, 1, 32'h1111_0004, 1, 0, 0);
    chk("zw_addr1", o_addr, 32'h104);
    cycle(0, 1, 32'h0, 1, 0, 0);
    chk("zw_ipc1", o_ipc, 32'h104);
    cycle(0, 1, 32'h1111_0008, 1, 0, 0);
    chk("zw_addr2", o_addr, 32'h108);
    cycle(0, 0, 32'h0, 1, 0, 0);

    // Three wait states then four cycles of backpressure
    for (int i = 0; i < 4; i++) begin
      cycle(0, i == 3, 32'h2222_010C, 0, 0, 0);
      chk("ws_addr", o_addr, 32'h10C);
      chk("ws_req", {31'b0, o_req}, 32'h1);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 32'hBAD0_0000, 0, 0, 0);
      chk("bp_valid", {31'b0, o_valid}, 32'h1);
      chk("bp_instr", o_instr, 32'h2222_010C);
      chk("bp_req", {31'b0, o_req}, 32'h0);
    end
    cycle(0, 0, 32'h0, 1, 0, 0);

    // Redirect in VALID wins over instr_ready
    cycle(0, 1, 32'h3333_0110, 0, 0, 0);
    chk("rv_addr", o_addr, 32'h110);
    cycle(0, 0, 32'h0, 1, 1, 32'h40);
    chk("rv_valid", {31'b0, o_valid}, 32'h1);

    // Redirect while a delayed ack is in flight
    cycle(0, 0, 32'h0, 1, 0, 0);
    chk("rf_addr0", o_addr, 32'h40);
    chk("rf_valid0", {31'b0, o_valid}, 32'h0);
    cycle(0, 0, 32'h0, 1, 1, 32'h80);
    cycle(0, 0, 32'h0, 1, 0, 0);
    chk("rf_hold", o_addr, 32'h40);
    cycle(0, 1, 32'hBAD0_0040, 1, 0, 0);
    chk("rf_hold2", o_addr, 32'h40);
    cycle(0, 1, 32'h4444_0080, 1, 0, 0);
    chk("rf_target", o_addr, 32'h80);
    chk("rf_novalid", {31'b0, o_valid}, 32'h0);
    cycle(0, 0, 32'h0, 1, 0, 0);
    chk("rf_instr", o_instr, 32'h4444_0080);

    // Redirect coincident with ack, misaligned target
    cycle(0, 1, 32'hBAD0_0084, 1, 1, 32'h203);
    chk("rc_addr", o_addr, 32'h84);
    cycle(0, 1, 32'h5555_0200, 1, 0, 0);
    chk("rc_target", o_addr, 32'h200);
    cycle(0, 0, 32'h0, 1, 0, 0);
    chk("rc_ipc", o_ipc, 32'h200);
    chk("rc_instr", o_instr, 32'h5555_0200);

    // Wrap from the top of the address space
    cycle(0, 0, 32'h0, 1, 1, 32'hFFFF_FFFC);
    cycle(0, 1, 32'hBAD0_0204, 1, 0, 0);
    cycle(0, 1, 32'h6666_FFFC, 1, 0, 0);
    chk("wr_addr", o_addr, 32'hFFFF_FFFC);
    cycle(0, 0, 32'h0, 1, 0, 0);
    chk("wr_ipc", o_ipc, 32'hFFFF_FFFC);
    cycle(0, 0, 32'h0, 1, 0, 0);
    chk("wr_zero", o_addr, 32'h0);
    chk("wr_req", {31'b0, o_req}, 32'h1);

    // Reset while draining an abandoned request
    cycle(0, 0, 32'h0, 1, 1, 32'h300);
    cycle(1, 0, 32'h0, 1, 0, 0);
    chk("mr_flush_req", {31'b0, o_req}, 32'h1);
    chk("mr_flush_addr", o_addr, 32'h0);
    cycle(0, 1, 32'hBAD0_0300, 1, 0, 0);
    chk("mr_idle_req", {31'b0, o_req}, 32'h0);
    cycle(0, 1, 32'h7777_0100, 1, 0, 0);
    chk("mr_restart", o_addr, 32'h100);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      d = $urandom;
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 4), d,
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) == 0), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage. It owns the program counter, issues word reads to instruction memory over a req/ack handshake, and buffers one fetched instruction. It presents that instruction, with its PC, to the decode/control stage over a valid/ready handshake. A taken branch from the execute stage redirects the PC and squashes any instruction that is buffered or still in flight.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset. Bits [1:0] must be 0.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- imem_req  out  1  read request to instruction memory; held until imem_ack.
- imem_addr  out  32  word address of the request; stable while imem_req=1.
- imem_ack  in  1  read data valid this cycle. Ignored when imem_req=0.
- imem_rdata  in  32  instruction word, sampled when imem_ack=1.
- instr  out  32  buffered instruction to decode/control.
- instr_pc  out  32  PC of `instr`.
- instr_valid  out  1  `instr`/`instr_pc` hold a live instruction.
- instr_ready  in  1  downstream accepts. A transfer occurs when instr_valid & instr_ready.
- redirect  in  1  taken branch (branch & zero from execute), one-cycle pulse.
- redirect_pc  in  32  branch target. Bits [1:0] are forced to 0 internally.

## Operation
- Registers:
  - pc (32): next address to fetch.
  - instr, instr_pc: output buffer.
  - state (2 bits): IDLE, FETCH, VALID, FLUSH.
- Outputs:
  - imem_req = 1 in FETCH and FLUSH, 0 otherwise.
  - imem_addr = pc in FETCH; in FLUSH, the latched address of the abandoned request.
  - instr_valid = 1 only in VALID.
- Reset, on any edge with rst=1:
  - pc = RESET_PC, state = IDLE.
  - instr = 0, instr_pc = 0, instr_valid = 0, imem_req = 0, imem_addr = 0.
  - rst overrides every other input.
- IDLE -> FETCH unconditionally on the next edge with rst=0.
- FETCH:
  - redirect=1 (with or without ack): pc <= redirect_pc & ~3. Any ack data is discarded.
    - If imem_ack=1: stay in FETCH.
    - If imem_ack=0: go to FLUSH. The memory request cannot be withdrawn.
  - Otherwise, on imem_ack=1: instr <= imem_rdata, instr_pc <= pc, pc <= pc+4, go to VALID.
  - Otherwise (no ack): stay in FETCH.
- VALID:
  - redirect=1: pc <= redirect_pc & ~3, go to FETCH. The buffered instruction is dropped, even if instr_ready=1 in the same cycle (redirect wins).
  - Otherwise, instr_ready=1: go to FETCH (instruction consumed).
  - Otherwise: hold instr, instr_pc and instr_valid unchanged.
- FLUSH:
  - imem_req stays high on the old address until imem_ack. The ack data is discarded, then go to FETCH with the new pc.
  - A further redirect in FLUSH overwrites pc; the last redirect wins.
- Arithmetic: pc+4 is 32-bit modulo, so 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Exactly one memory request is outstanding at a time. The instruction buffer holds one entry.

## Timing
- Zero-wait memory (ack in the same cycle as req): one instruction every 2 cycles, FETCH then VALID. instr_valid rises on the edge after the ack.
- N wait cycles: FETCH lasts N+1 cycles.
- Redirect to first request on the target address:
  - From FETCH or VALID: the next cycle.
  - From FLUSH: the cycle after the old ack.
- instr and instr_pc change only on entry to VALID. They are stable for the whole VALID residency (downstream backpressure).
- There is no combinational path from instr_ready or redirect to any output. All outputs are functions of registered state.

## Test plan
- Reset sequence:
  - Stimulus: rst high 2 cycles with RESET_PC=32'h100, zero-wait memory, instr_ready=1.
  - Response: all outputs 0 during reset. imem_addr reads 32'h100, 32'h104, 32'h108 on alternate cycles. instr_pc tracks the same values.
- Wait states and backpressure:
  - Stimulus: ack delayed 3 cycles; instr_ready held 0 for 4 cycles.
  - Response: imem_req/imem_addr stable for 4 cycles. instr_valid=1 with instr constant for 4 cycles. No new request until instr_ready=1.
- Redirect in VALID:
  - Stimulus: redirect with redirect_pc=32'h40 while instr_ready=1.
  - Response: the buffered instruction is not consumed. The next request is at 32'h40.
- Redirect in flight:
  - Stimulus: redirect while FETCH waits on an ack delayed 2 cycles.
  - Response: imem_addr holds the old address until the ack. The ack data never appears on instr. The next request is at the target.
- Redirect coincident with ack:
  - Stimulus: redirect and imem_ack in the same cycle.
  - Response: the data is dropped and the next cycle requests the target.
- Misaligned target and wrap:
  - Stimulus 1: redirect_pc=32'h203. Response: fetch at 32'h200.
  - Stimulus 2: redirect_pc=32'hFFFF_FFFC. Response: fetches at FFFF_FFFC, then 0000_0000.
- Mid-operation reset:
  - Stimulus: rst asserted in FLUSH.
  - Response: state=IDLE, imem_req=0 the next cycle. The late ack is ignored. Fetch restarts at RESET_PC.
